// File: rtl/beaker8_pkg.sv
// ============================================================================
// Module  : beaker8_pkg
// Brief   : Shared types and constants for the Beaker8 ROM fetch path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package beaker8_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 16;
   localparam logic [DEFAULT_ADDR_WIDTH-1:0] DEFAULT_RESET_VECTOR = '0;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      STALL = 2'd0,
      READ  = 2'd1,
      WAIT  = 2'd2
   } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module  : fetch_fifo
// Brief   : Synchronous prefetch FIFO of {address, byte} with push/pop/flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
   import beaker8_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = DEFAULT_ADDR_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push_i,
   input  logic                        pop_i,
   input  logic                        flush_i,
   input  logic [7:0]                  push_data_i,
   input  logic [AW-1:0]               push_addr_i,
   output logic [$clog2(DEPTH):0]      count_o,
   output logic [7:0]                  head_data_o,
   output logic [AW-1:0]               head_addr_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    data_q [DEPTH];
   logic [AW-1:0] addr_q [DEPTH];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   // A push into a full FIFO is only legal when the head leaves on the same edge.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            data_q[wr_q] <= push_data_i;
            addr_q[wr_q] <= push_addr_i;
            wr_q         <= wr_q + 1'b1;
         end
         if (do_pop) begin
            rd_q <= rd_q + 1'b1;
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign count_o     = count_q;
   assign head_data_o = data_q[rd_q];
   assign head_addr_o = addr_q[rd_q];

endmodule

`default_nettype wire

// File: rtl/rom_fetcher.sv
// ============================================================================
// Module  : rom_fetcher
// Brief   : Beaker8 ROM bus initiator with prefetch FIFO and jump redirect.
//           Optional wait states enabled by defining FETCH_WAIT_STATES_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_fetcher
   import beaker8_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int                    DEPTH        = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                    WAIT_CYCLES  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  chipSelect,
   output logic [ADDR_WIDTH-1:0] address,
   input  logic [7:0]            data,
   input  logic                  jumpValid,
   input  logic [ADDR_WIDTH-1:0] jumpAddress,
   output logic                  byteValid,
   output logic [7:0]            byteData,
   output logic [ADDR_WIDTH-1:0] byteAddress,
   input  logic                  byteReady
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e          state_q, state_d;
   logic                  cs_q, cs_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_after;
   logic                  push;
   logic                  pop;
   logic                  issue_req;
   logic                  issue_ok;

`ifdef FETCH_WAIT_STATES_EN
   logic [WAIT_CNT_W-1:0] wait_q, wait_d;
`else
   logic unused_wait_cfg;
   assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

   always_comb begin
      pop         = (count != '0) && byteReady && !jumpValid;
      push        = (state_q == READ) && !jumpValid;
      count_after = count + CW'(push) - CW'(pop);
      state_d     = state_q;
      cs_d        = cs_q;
      addr_d      = addr_q;
      pc_d        = pc_q;
      issue_req   = 1'b0;
`ifdef FETCH_WAIT_STATES_EN
      wait_d      = wait_q;
`endif
      if (jumpValid) begin
         pc_d      = jumpAddress;
         issue_req = 1'b1;
      end else begin
         case (state_q)
            STALL: issue_req = 1'b1;
            READ: begin
               pc_d      = pc_q + 1'b1;
               issue_req = 1'b1;
            end
`ifdef FETCH_WAIT_STATES_EN
            WAIT: begin
               if (wait_q <= WAIT_CNT_W'(1)) begin
                  state_d = READ;
               end
               wait_d = wait_q - 1'b1;
            end
`endif
            default: ;
         endcase
      end

      // A flush empties the FIFO, so a jump always issues.
      issue_ok = jumpValid || (count_after < CW'(DEPTH));
      if (issue_req) begin
         if (issue_ok) begin
            cs_d   = 1'b1;
            addr_d = pc_d;
`ifdef FETCH_WAIT_STATES_EN
            if (WAIT_CYCLES != 0) begin
               state_d = WAIT;
               wait_d  = WAIT_CNT_W'(WAIT_CYCLES);
            end else begin
               state_d = READ;
            end
`else
            state_d = READ;
`endif
         end else begin
            state_d = STALL;
            cs_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= STALL;
         cs_q    <= 1'b0;
         addr_q  <= RESET_VECTOR;
         pc_q    <= RESET_VECTOR;
`ifdef FETCH_WAIT_STATES_EN
         wait_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cs_q    <= cs_d;
         addr_q  <= addr_d;
         pc_q    <= pc_d;
`ifdef FETCH_WAIT_STATES_EN
         wait_q  <= wait_d;
`endif
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .AW    (ADDR_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (jumpValid),
      .push_data_i (data),
      .push_addr_i (addr_q),
      .count_o     (count),
      .head_data_o (byteData),
      .head_addr_o (byteAddress)
   );

   assign chipSelect = cs_q;
   assign address    = addr_q;
   assign byteValid  = (count != '0);

endmodule

`default_nettype wire

// File: doc/rom_fetcher.md
# rom_fetcher

Bus initiator that reads the Beaker8 boot/program ROM on behalf of the CPU core. It drives the ROM's chip select and address, samples the returned byte, and queues bytes in a small prefetch FIFO presented to the decoder through a valid/ready handshake. It sits between the core's decode stage and the ROM chip-select/address/data bus, and redirects the fetch stream on jumps.

## Interface
- ADDR_WIDTH, 16: width of the ROM address bus and program counter.
- DEPTH, 4: prefetch FIFO depth in bytes (power of two, 2..16).
- RESET_VECTOR, 0: first address fetched after reset.
- WAIT_CYCLES, 0: extra bus cycles per read (0..15); used only with FETCH_WAIT_STATES_EN.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- chipSelect  out  1  ROM select, registered.
- address  out  ADDR_WIDTH  ROM address, registered.
- data  in  8  ROM read data; valid while chipSelect high.
- jumpValid  in  1  one-cycle redirect request.
- jumpAddress  in  ADDR_WIDTH  redirect target.
- byteValid  out  1  FIFO head valid.
- byteData  out  8  FIFO head byte.
- byteAddress  out  ADDR_WIDTH  ROM address the head byte came from.
- byteReady  in  1  decoder accepts head byte.

## Operation
- States: STALL (chipSelect=0), READ (chipSelect=1, address=pc, completing), WAIT (chipSelect=1, address held, waitCount>0).
- Reset values: chipSelect=0, address=RESET_VECTOR, byteValid=0, byteData=0, byteAddress=0, pc=RESET_VECTOR, FIFO empty, state STALL.
- Each edge, priority order: reset > jump > normal.
- Jump: FIFO flushed, in-flight read discarded (not captured), pc=jumpAddress; next state READ at jumpAddress. byteReady in the same cycle ignored.
- Normal: in a completing READ cycle, data captured with address into FIFO, pc increments (wraps 2^ADDR_WIDTH-1 -> 0). Pop when byteValid && byteReady. Push and pop may coincide, including when full (count unchanged).
- Issue rule: next state READ/WAIT iff count after this edge's push/pop < DEPTH, else STALL. Captures never overflow.
- byteValid = count != 0; byteData/byteAddress = FIFO head, driven from registers.
- No partial outputs: chipSelect never glitches; address changes only on edges.

## Timing
- Reset released at edge E0 (reset low at E0): chipSelect=1, address=RESET_VECTOR after E0; byte captured at E1; byteValid=1 after E1.
- Zero wait: one byte per cycle, chipSelect held high continuously while not full, address increments every cycle.
- Jump sampled at edge J: chipSelect=1, address=jumpAddress after J; byteValid=0 after J; first new byte valid after J+1+WAIT_CYCLES.
- Full -> STALL: one pop at edge P re-issues; chipSelect=1 after P.
- Reset mid-read: read abandoned, no capture, reset values after that edge.

## Configuration
- FETCH_WAIT_STATES_EN defined: each read holds chipSelect/address for 1+WAIT_CYCLES cycles (READ entered after WAIT counts down), data sampled only on final edge; back-to-back reads need no idle cycle.
- Undefined: WAIT state and counter absent; every read completes in one cycle; WAIT_CYCLES ignored.

## Structure
- beaker8_pkg: fetch state enum (STALL, READ, WAIT), default ADDR_WIDTH, RESET_VECTOR constant.
- Sub-module fetch_fifo: synchronous FIFO of {address, byte}, DEPTH entries, push/pop/flush, count output; fetcher holds FSM, pc and wait counter.

## Test plan
- Reset release, ROM = 0x10,0x11,0x12..., byteReady=1 -> chipSelect high from cycle after release, bytes 0x10,0x11,0x12 with byteAddress 0,1,2 one per cycle.
- byteReady=0, DEPTH=4 -> exactly 4 reads (addr 0..3), chipSelect low; one pop -> single read of addr 4.
- jumpValid with jumpAddress=0x0100 while FIFO holds 3 bytes -> byteValid low next cycle, next byte is ROM[0x0100] at byteAddress 0x0100.
- RESET_VECTOR=0xFFFE, DEPTH=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- FETCH_WAIT_STATES_EN, WAIT_CYCLES=2 -> each address held 3 cycles, throughput one byte per 3 cycles; data changed mid-hold not captured.
- Reset asserted mid-stream with full FIFO -> after edge: chipSelect=0, byteValid=0, address=RESET_VECTOR; fetch restarts from vector.
